// File: rtl/apb_uart.sv
// apb_uart: APB slave UART, 8N1 LSB first, with a TX FIFO, a single-byte RX holding register,
// a programmable baud divider and a level interrupt.
module apb_uart #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [3:0]            PBE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic                  irq
);
    localparam int PW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [1:0]    sel;
    logic          access, wr, rd, push, pop, tx_full, tx_empty, tx_busy;
    logic [7:0]    fifo_q [TX_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic [15:0]   div_q, div_wr;
    logic [3:0]    ctrl_q;
    logic          unused;

    tx_state_e     tx_state_q, tx_state_d;
    logic [15:0]   tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_line_q, tx_line_d, tx_tick;

    rx_state_e     rx_state_q, rx_state_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_byte_q;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_tick, rx_done, rx_ferr_set;
    logic          rx_valid_q, overrun_q, ferr_q, rd_data, rd_stat;

    assign unused   = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PBE[3:2], PWDATA[31:16]};
    assign sel      = PADDR[3:2];
    assign tx_full  = cnt_q == (PW+1)'(TX_DEPTH);
    assign tx_empty = cnt_q == '0;
    assign tx_busy  = tx_state_q != TX_IDLE;
    assign PREADY   = ~(PSEL & PENABLE & PWRITE & (sel == 2'd0) & tx_full);
    assign access   = PSEL & PENABLE & PREADY;
    assign wr       = access & PWRITE;
    assign rd       = access & ~PWRITE;
    assign rd_data  = rd & (sel == 2'd0);
    assign rd_stat  = rd & (sel == 2'd1);
    assign push     = wr & (sel == 2'd0) & PBE[0];
    assign pop      = (tx_state_q == TX_IDLE) & ctrl_q[0] & ~tx_empty;
    assign div_wr   = {PBE[1] ? PWDATA[15:8] : div_q[15:8], PBE[0] ? PWDATA[7:0] : div_q[7:0]};
    assign uart_tx  = tx_line_q;
    assign irq      = (rx_valid_q & ctrl_q[2]) | (tx_empty & ~tx_busy & ctrl_q[3]);

    always_comb begin
        PRDATA = '0;
        if (PSEL)
            PRDATA = (sel == 2'd0) ? {24'b0, rx_byte_q} :
                     (sel == 2'd1) ? {26'b0, ferr_q, overrun_q, rx_valid_q, tx_busy, tx_empty, tx_full} :
                     (sel == 2'd2) ? {16'b0, div_q} : {28'b0, ctrl_q};
    end

    always_ff @(posedge PCLK) begin
        if (push) fifo_q[wptr_q] <= PWDATA[7:0];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            div_q  <= DEFAULT_DIV;
            ctrl_q <= 4'h3;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (wr && sel == 2'd2) div_q <= (div_wr < 16'd7) ? 16'd7 : div_wr;
            if (wr && sel == 2'd3 && PBE[0]) ctrl_q <= PWDATA[3:0];
        end
    end

    // The divider is re-latched at every bit boundary so BAUDDIV writes never split a bit.
    assign tx_tick = tx_cnt_q == tx_div_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 16'd1;
            tx_div_d = tx_tick ? div_q : tx_div_q;
        end
        case (tx_state_q)
            TX_IDLE: if (pop) begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_div_d   = div_q;
                tx_sh_d    = fifo_q[rptr_q];
                tx_line_d  = 1'b0;
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
                tx_line_d  = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_line_d = tx_sh_q[0];
                    tx_sh_d   = tx_sh_q >> 1;
                    tx_bit_d  = tx_bit_q + 3'd1;
                end
            end
            TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DEFAULT_DIV;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign rx_tick = rx_cnt_q == rx_div_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_div_d    = rx_div_q;
        rx_sh_d     = rx_sh_q;
        rx_bit_d    = rx_bit_q;
        rx_done     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_q;
                end
            end
            RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_div_d   = div_q;
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
                rx_cnt_d   = '0;
                rx_div_d   = div_q;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_d  = RX_IDLE;
                rx_done     = rx_s2_q;
                rx_ferr_set = ~rx_s2_q;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DEFAULT_DIV;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            // A DATA read on the completion edge frees the holder, so the new byte is not an overrun.
            if (rx_done && (!rx_valid_q || rd_data)) rx_byte_q <= rx_sh_q;
            rx_valid_q <= rx_done | (rx_valid_q & ~rd_data);
            overrun_q  <= (overrun_q & ~rd_stat) | (rx_done & rx_valid_q & ~rd_data);
            ferr_q     <= (ferr_q & ~rd_stat) | rx_ferr_set;
        end
    end
endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: directed scoreboard bench; reads and serial frames are checked by monitors.
module tb_apb_uart;
    logic        PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, uart_rx = 1;
    logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
    logic [3:0]  PBE = 0;
    logic        PREADY, uart_tx, irq;

    apb_uart dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PBE(PBE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0, cyc = 0, bitp = 8;
    logic [31:0] rd_val_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];
    int          tx_starts[$];
    bit          rst_seen = 0;
    logic [7:0]  mon_b;
    logic        mon_start, mon_stop;

    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PRESETn) rst_seen = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY && !PWRITE) begin
            if (rd_val_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got 0x%0h expected no read", PRDATA);
            end else check(rd_name_q.pop_front(), PRDATA, rd_val_q.pop_front());
        end
    end

    initial forever begin
        @(negedge PCLK);
        if (PRESETn && uart_tx === 1'b0) begin
            rst_seen = 0;
            tx_starts.push_back(cyc);
            repeat (bitp / 2) @(negedge PCLK);
            mon_start = ~uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (bitp) @(negedge PCLK);
                mon_b[i] = uart_tx;
            end
            repeat (bitp) @(negedge PCLK);
            mon_stop = uart_tx;
            if (!rst_seen) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: got 0x%0h expected no frame", mon_b);
                end else check("tx_frame", {mon_start, mon_stop, mon_b}, {2'b11, tx_q.pop_front()});
            end
        end
    end

    task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output int waits, output int done_cyc);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d; PBE = be;
        @(posedge PCLK); #1;
        PENABLE = 1;
        waits = 0;
        @(negedge PCLK);
        while (!PREADY && waits < 2000) begin
            waits++;
            @(negedge PCLK);
        end
        if (!PREADY) begin
            checks++; errors++;
            $display("FAIL apb_timeout: got PREADY=0 expected 1 at addr 0x%0h", a);
        end
        @(posedge PCLK); #1;
        done_cyc = cyc;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w, c;
        apb(1, a, d, 4'hF, w, c);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        int w, c;
        rd_val_q.push_back(exp);
        rd_name_q.push_back(name);
        apb(0, a, 0, 4'hF, w, c);
    endtask

    task automatic rx_bit(input logic v);
        @(posedge PCLK); #1;
        uart_rx = v;
        repeat (7) @(posedge PCLK);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_bit(0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
        rx_bit(1);
        rx_bit(1);
    endtask

    task automatic wait_tx();
        int t = 0;
        while (tx_q.size() != 0 && t < 5000) begin
            @(negedge PCLK);
            t++;
        end
        repeat (10) @(negedge PCLK);
    endtask

    initial begin
        int n, t;
        int waits[6], done[6];
        logic [7:0] bytes[6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq", irq, 0);
        check("rst_pready", PREADY, 1);
        check("rst_prdata", PRDATA, 0);
        rd(32'h0, 32'h0, "rst_data");
        rd(32'h4, 32'h2, "rst_status");
        rd(32'h8, 32'h1B2, "rst_bauddiv");
        rd(32'hC, 32'h3, "rst_ctrl");

        wr(32'h8, 32'h3);
        rd(32'h8, 32'h7, "div_clamp");
        apb(1, 32'h8, 32'h0000AB09, 4'h1, n, t);
        rd(32'h8, 32'h9, "div_byte_en");
        wr(32'h8, 32'h7);
        rd(32'h8, 32'h7, "div_set");

        tx_q.push_back(8'hA5);
        wr(32'h0, 32'hA5);
        t = 0;
        while (uart_tx !== 1'b0 && t < 20) begin
            @(negedge PCLK);
            t++;
        end
        check("tx_latency", t, 2);
        n = 0;
        while (uart_tx === 1'b0 && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        check("start_len", n, 8);
        wait_tx();
        rd(32'h4, 32'h2, "tx_done_status");

        tx_starts.delete();
        for (int i = 0; i < 6; i++) begin
            tx_q.push_back(bytes[i]);
            apb(1, 32'h0, {24'h0, bytes[i]}, 4'hF, waits[i], done[i]);
        end
        for (int i = 0; i < 5; i++) check("no_stall", waits[i], 0);
        check("stall_seen", waits[5] > 0, 1);
        check("stall_release", done[5] - (tx_starts.size() > 1 ? tx_starts[1] : 0), 1);
        wait_tx();
        check("frame_count", tx_starts.size(), 6);
        for (int i = 1; i < 6 && i < tx_starts.size(); i++)
            check("frame_gap", tx_starts[i] - tx_starts[i-1], 81);
        rd(32'h4, 32'h2, "b2b_status");

        send_rx(8'h3C, 1);
        send_rx(8'h81, 1);
        rd(32'h4, 32'h1A, "rx_ovr_status");
        rd(32'h0, 32'h3C, "rx_data");
        rd(32'h4, 32'h02, "rx_ovr_clear");
        send_rx(8'h55, 0);
        rd(32'h4, 32'h22, "rx_ferr");
        rd(32'h4, 32'h02, "rx_ferr_clear");
        @(posedge PCLK); #1 uart_rx = 0;
        repeat (2) @(posedge PCLK);
        #1 uart_rx = 1;
        repeat (40) @(posedge PCLK);
        rd(32'h4, 32'h02, "glitch_status");
        rd(32'h0, 32'h3C, "glitch_data");

        wr(32'hC, 32'hC);
        @(negedge PCLK);
        check("irq_empty", irq, 1);
        wr(32'hC, 32'h9);
        tx_q.push_back(8'h5A);
        wr(32'h0, 32'h5A);
        n = 0;
        @(negedge PCLK);
        while (irq === 1'b0 && n < 2000) begin
            n++;
            @(negedge PCLK);
        end
        check("irq_low_len", n, 81);
        check("irq_after", irq, 1);
        wait_tx();

        wr(32'hC, 32'h3);
        wr(32'h0, 32'h00);
        repeat (20) @(negedge PCLK);
        check("pre_rst_tx", uart_tx, 0);
        #2 PRESETn = 0;
        #1 check("rst_async_tx", uart_tx, 1);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
        rd(32'h4, 32'h2, "post_rst_status");
        rd(32'h8, 32'h1B2, "post_rst_div");
        rd(32'hC, 32'h3, "post_rst_ctrl");
        repeat (100) @(posedge PCLK);
        check("rd_q_empty", rd_val_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
